lda_cmd_queue: RTL and testbench

//  Upstream command stage for the line-drawing engine. Accepts line commands (x0,y0,x1,y1,colour)

---
 rtl/lda_pkg.sv | 29 ++
 rtl/lda_cmd_fifo.sv | 59 +++++
 rtl/lda_cmd_queue.sv | 128 ++++++++++++
 tb/tb_lda_cmd_queue.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lda_pkg.sv
// Shared types for the line-drawing command queue: the queued command
// record and the issue state machine encoding.
package lda_pkg;

  localparam int LINE_X_W = 9;  // 320-pixel screen
  localparam int LINE_Y_W = 8;  // 240-line screen
  localparam int LINE_C_W = 3;  // colour index

  // One queued line command; field order is the order the host presents it.
  typedef struct packed {
    logic [LINE_X_W-1:0] x0;
    logic [LINE_X_W-1:0] x1;
    logic [LINE_Y_W-1:0] y0;
    logic [LINE_Y_W-1:0] y1;
    logic [LINE_C_W-1:0] colour;
  } line_cmd_t;

  localparam int LINE_CMD_W = $bits(line_cmd_t);

  // Issue sequencing: pop in IDLE, pulse start in ISSUE, hold in WAIT,
  // one dead cycle in GAP so the LDA can settle back to idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } lda_state_t;

endpackage

// File: rtl/lda_cmd_fifo.sv
// Synchronous FIFO of line commands. Pointers carry an extra wrap bit so
// full and empty come straight from a pointer compare. Flush clears both
// pointers and overrides any push or pop in the same cycle. The head entry
// is read combinationally so the consumer can pop it into its own register
// on the same edge.
module lda_cmd_fifo
  import lda_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  line_cmd_t push_data,
  input  logic      pop,
  input  logic      flush,
  output line_cmd_t head,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  line_cmd_t   mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  // Flush takes priority; a full FIFO refuses pushes, an empty one refuses pops.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  // Pointer update: flush clears both, otherwise advance on accepted push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lda_cmd_queue.sv
// Command stage in front of the line-drawing engine. Buffers host line
// commands and hands them to the LDA one at a time: start pulse, operands
// held until the LDA reports done, then a dead cycle before the next line.
module lda_cmd_queue
  import lda_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int X_W   = LINE_X_W,
  parameter int Y_W   = LINE_Y_W,
  parameter int C_W   = LINE_C_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [X_W-1:0]   cmd_x0,
  input  logic [X_W-1:0]   cmd_x1,
  input  logic [Y_W-1:0]   cmd_y0,
  input  logic [Y_W-1:0]   cmd_y1,
  input  logic [C_W-1:0]   cmd_colour,
  input  logic             flush,
  output logic             lda_start,
  output logic [X_W-1:0]   lda_x0,
  output logic [X_W-1:0]   lda_x1,
  output logic [Y_W-1:0]   lda_y0,
  output logic [Y_W-1:0]   lda_y1,
  output logic [C_W-1:0]   lda_colour,
  input  logic             lda_done,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      lines_done
);

  lda_state_t state_reg;
  lda_state_t state_next;
  line_cmd_t  op_reg;
  line_cmd_t  in_cmd;
  line_cmd_t  fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       pop;
  logic       armed_reg;
  logic [15:0] lines_done_reg;

  assign in_cmd.x0     = cmd_x0;
  assign in_cmd.x1     = cmd_x1;
  assign in_cmd.y0     = cmd_y0;
  assign in_cmd.y1     = cmd_y1;
  assign in_cmd.colour = cmd_colour;

  // Ready depends only on registered state, never on cmd_valid. armed_reg
  // keeps it low during reset and for the first edge after release.
  assign cmd_ready = armed_reg & ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;

  lda_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_cmd),
    .pop       (pop),
    .flush     (flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Ready enable: goes high on the first edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) armed_reg <= 1'b0;
    else        armed_reg <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and pop decision; a flush in IDLE suppresses the pop.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !flush) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (lda_done) state_next = ST_GAP;
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture on pop; held untouched through ISSUE, WAIT and GAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   op_reg <= '0;
    else if (pop) op_reg <= fifo_head;
  end

  // Completed-line counter; done is only honoured while waiting on a line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lines_done_reg <= 16'd0;
    else if (state_reg == ST_WAIT && lda_done)
      lines_done_reg <= lines_done_reg + 16'd1;
  end

  assign lda_start  = (state_reg == ST_ISSUE);
  assign busy       = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign lines_done = lines_done_reg;
  assign lda_x0     = op_reg.x0;
  assign lda_x1     = op_reg.x1;
  assign lda_y0     = op_reg.y0;
  assign lda_y1     = op_reg.y1;
  assign lda_colour = op_reg.colour;

endmodule

// File: tb/tb_lda_cmd_queue.sv
// Scoreboard bench for lda_cmd_queue: stimulus pushes expected commands,
// a monitor/LDA model pops and compares at every lda_start.
module tb_lda_cmd_queue;
  import lda_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [LINE_X_W-1:0] cmd_x0, cmd_x1;
  logic [LINE_Y_W-1:0] cmd_y0, cmd_y1;
  logic [LINE_C_W-1:0] cmd_colour;
  logic                flush;
  logic                lda_start;
  logic [LINE_X_W-1:0] lda_x0, lda_x1;
  logic [LINE_Y_W-1:0] lda_y0, lda_y1;
  logic [LINE_C_W-1:0] lda_colour;
  logic                lda_done;
  logic                busy;
  logic [3:0]          count;
  logic [15:0]         lines_done;

  logic      model_done;
  logic      spur_done;
  logic      lda_stall;
  int        lda_delay;
  int        n_cmp;
  int        n_err;
  line_cmd_t exp_q[$];

  assign lda_done = model_done | spur_done;

  lda_cmd_queue #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_colour(cmd_colour), .flush(flush), .lda_start(lda_start),
    .lda_x0(lda_x0), .lda_x1(lda_x1), .lda_y0(lda_y0), .lda_y1(lda_y1),
    .lda_colour(lda_colour), .lda_done(lda_done), .busy(busy),
    .count(count), .lines_done(lines_done)
  );

  function automatic line_cmd_t mk(input int x0, input int y0, input int x1,
                                   input int y1, input int c);
    line_cmd_t r;
    r.x0 = x0[LINE_X_W-1:0];
    r.x1 = x1[LINE_X_W-1:0];
    r.y0 = y0[LINE_Y_W-1:0];
    r.y1 = y1[LINE_Y_W-1:0];
    r.colour = c[LINE_C_W-1:0];
    return r;
  endfunction

  function automatic line_cmd_t dut_ops();
    line_cmd_t r;
    r.x0 = lda_x0; r.x1 = lda_x1; r.y0 = lda_y0; r.y1 = lda_y1;
    r.colour = lda_colour;
    return r;
  endfunction

  function automatic logic [63:0] all_out();
    return {4'd0, cmd_ready, lda_start, busy, count, lines_done, dut_ops()};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out, got no event, required one", name);
  endtask

  // Monitor plus LDA model: compares each issued command with the scoreboard,
  // checks operands stay frozen, and raises done after lda_delay cycles.
  task automatic monitor();
    line_cmd_t cur;
    line_cmd_t e;
    int        cnt = 0;
    bit        active = 1'b0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (!reset) begin
        active = 1'b0;
      end else if (lda_start) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_start: got lda_start=1 ops=0x%0h, required no start", dut_ops());
          cur = dut_ops();
        end else begin
          e = exp_q.pop_front();
          chk("issue", {27'd0, dut_ops()}, {27'd0, e});
          cur = e;
        end
        active = 1'b1;
        cnt = lda_delay;
      end else if (active) begin
        chk("hold", {27'd0, dut_ops()}, {27'd0, cur});
        if (!lda_stall) begin
          if (cnt <= 1) begin
            model_done = 1'b1;
            active = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  endtask

  task automatic push_cmd(input line_cmd_t c, input int budget);
    int waited = 0;
    cmd_x0 = c.x0; cmd_x1 = c.x1; cmd_y0 = c.y0; cmd_y1 = c.y1;
    cmd_colour = c.colour;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) begin
      timeout_fail("push_accept");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(c);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && (busy || lda_start || count != 0 || exp_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout_fail("wait_idle");
    repeat (3) @(negedge clk);
  endtask

  // Returns just after the edge that sampled the model's done (DUT now in GAP).
  task automatic wait_done_edge(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!lda_done && n < budget);
    if (!lda_done) timeout_fail("wait_done");
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; flush = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_colour = '0;
    model_done = 1'b0; spur_done = 1'b0; lda_stall = 1'b0; lda_delay = 7;
    n_cmp = 0; n_err = 0;
    fork
      monitor();
      begin
        #200us;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_out(), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); #1;
    chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    // 1: single command, latency and completion
    lda_delay = 7;
    push_cmd(mk(10, 20, 100, 50, 5), 20);
    @(negedge clk);
    chk("lat_cycle1_start", {63'd0, lda_start}, 64'd0);
    chk("lat_cycle1_count", {60'd0, count}, 64'd1);
    @(negedge clk);
    chk("lat_cycle2_start", {63'd0, lda_start}, 64'd1);
    chk("lat_cycle2_count", {60'd0, count}, 64'd0);
    wait_idle(100);
    chk("t1_lines_done", {48'd0, lines_done}, 64'd1);

    // 2: fill while the LDA stalls, tenth command blocked until a pop
    lda_stall = 1'b1;
    lda_delay = 2;
    for (int i = 0; i < 9; i++) push_cmd(mk(i * 3, i * 2, 300 - i, 200 - i, i % 8), 20);
    chk("full_count", {60'd0, count}, 64'd8);
    chk("full_ready", {63'd0, cmd_ready}, 64'd0);
    cmd_x0 = 9'd27; cmd_x1 = 9'd291; cmd_y0 = 8'd18; cmd_y1 = 8'd191; cmd_colour = 3'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("blocked_count", {60'd0, count}, 64'd8);
    end
    lda_stall = 1'b0;
    push_cmd(mk(27, 18, 291, 191, 1), 50);
    wait_idle(300);
    chk("t2_lines_done", {48'd0, lines_done}, 64'd11);

    // 3: push and pop on the same edge at count=3
    lda_stall = 1'b1;
    lda_delay = 3;
    for (int i = 0; i < 4; i++) push_cmd(mk(40 + i, 60 + i, 140 + i, 160 + i, 7 - i), 20);
    chk("pp_setup_count", {60'd0, count}, 64'd3);
    lda_stall = 1'b0;
    wait_done_edge(50);
    @(posedge clk); #1;
    chk("pp_before_count", {60'd0, count}, 64'd3);
    push_cmd(mk(1, 2, 3, 4, 6), 5);
    chk("pp_after_count", {60'd0, count}, 64'd3);
    chk("pp_after_start", {63'd0, lda_start}, 64'd1);
    wait_idle(200);
    chk("t3_lines_done", {48'd0, lines_done}, 64'd16);

    // 4: flush with 4 queued and 1 in flight, with a push on the flush edge
    lda_stall = 1'b1;
    lda_delay = 4;
    for (int i = 0; i < 5; i++) push_cmd(mk(200 + i, 100 + i, 5 + i, 7 + i, i), 20);
    chk("fl_setup_count", {60'd0, count}, 64'd4);
    cmd_x0 = 9'd99; cmd_x1 = 9'd99; cmd_y0 = 8'd99; cmd_y1 = 8'd99; cmd_colour = 3'd3;
    cmd_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("fl_count", {60'd0, count}, 64'd0);
    chk("fl_busy", {63'd0, busy}, 64'd1);
    lda_stall = 1'b0;
    wait_idle(100);
    repeat (8) @(negedge clk);
    chk("t4_lines_done", {48'd0, lines_done}, 64'd17);

    // flush in IDLE with one entry: no pop
    cmd_x0 = 9'd5; cmd_x1 = 9'd6; cmd_y0 = 8'd7; cmd_y1 = 8'd8; cmd_colour = 3'd2;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("if_pre_count", {60'd0, count}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("if_count", {60'd0, count}, 64'd0);
    chk("if_busy", {62'd0, busy, lda_start}, 64'd0);
    repeat (6) @(negedge clk);
    chk("if_lines_done", {48'd0, lines_done}, 64'd17);

    // 5: asynchronous reset during WAIT
    lda_stall = 1'b1;
    push_cmd(mk(12, 34, 56, 78, 4), 20);
    repeat (3) @(negedge clk);
    chk("rw_busy", {63'd0, busy}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_async_outputs", all_out(), 64'd0);
    exp_q.delete();
    lda_stall = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rw_ready_first", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); #1;
    chk("rw_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rw_idle", {36'd0, lda_start, busy, count, lines_done, 6'd0}, 64'd0);

    // 6: spurious done in IDLE and GAP; counter wrap from 0xFFFF
    force dut.lines_done_reg = 16'hFFFF;
    @(posedge clk); #1;
    release dut.lines_done_reg;
    spur_done = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    spur_done = 1'b0;
    chk("sp_idle_lines", {48'd0, lines_done}, 64'hFFFF);
    chk("sp_idle_busy", {63'd0, busy}, 64'd0);
    lda_delay = 4;
    push_cmd(mk(319, 239, 0, 0, 7), 20);
    wait_done_edge(50);
    spur_done = 1'b1;
    chk("wrap_lines", {48'd0, lines_done}, 64'd0);
    chk("gap_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("sp_gap_lines", {48'd0, lines_done}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
